// File: rtl/bias_ctrl.sv
// Bias sequencer: adds bias[idx] to each incoming neuron sum (1-cycle registered
// output) and, in training passes, applies a saturating gradient step to that bias.
module bias_ctrl #(
  parameter int N_NEUR = 8,
  parameter int FRAC   = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_ce,
  input  logic                      start,
  input  logic                      training,
  input  logic [15:0]               eta,
  input  logic                      init_wr,
  input  logic [$clog2(N_NEUR)-1:0] init_addr,
  input  logic [15:0]               init_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               sum_in,
  input  logic [15:0]               delta_k,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_net,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = $clog2(N_NEUR);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      idx;
  logic signed [15:0] bias [N_NEUR];
  logic               tr_q;
  logic signed [15:0] eta_q;
  logic               accept, last;
  logic signed [15:0] cur_bias, fwd, upd;
  logic signed [31:0] prod, step_wide;

  function automatic logic signed [31:0] sx(input logic signed [15:0] v);
    return v;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)  return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  assign accept   = in_valid && in_ready;
  assign last     = (idx == IW'(N_NEUR - 1));
  assign cur_bias = bias[idx];

  // Forward sum and update both read the pre-update bias.
  always_comb begin
    prod      = $signed(delta_k) * eta_q;
    step_wide = prod >>> FRAC;
    fwd       = sat16(sx(cur_bias) + sx(sum_in));
    upd       = sat16(sx(cur_bias) - sx(sat16(step_wide)));
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)  state <= IDLE;
    else if (ap_ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    busy     = (state != IDLE);
    done     = (state == FIN);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx       <= '0;
      tr_q      <= 1'b0;
      eta_q     <= '0;
      out_net   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_NEUR; i++) bias[i] <= '0;
    end else if (ap_ce) begin
      if (state == IDLE) begin
        if (init_wr) bias[init_addr] <= init_data;
        if (start) begin
          idx   <= '0;
          tr_q  <= training;
          eta_q <= eta;
        end
      end
      if (accept) begin
        out_net   <= fwd;
        out_valid <= 1'b1;
        if (tr_q) bias[idx] <= upd;
        // idx parks on the last entry instead of wrapping.
        if (!last) idx <= idx + IW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_ctrl.sv
// Randomized bench for bias_ctrl against a pass-level reference model.
module tb_bias_ctrl;
  localparam int N    = 8;
  localparam int FRAC = 8;
  localparam int IW   = $clog2(N);

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_ce, start, training, init_wr, in_valid, out_ready;
  logic [15:0]   eta, init_data, sum_in, delta_k;
  logic [IW-1:0] init_addr;
  logic          in_ready, out_valid, busy, done;
  logic [15:0]   out_net;

  always #5 ap_clk = ~ap_clk;

  bias_ctrl #(.N_NEUR(N), .FRAC(FRAC)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_ce(ap_ce), .start(start),
    .training(training), .eta(eta), .init_wr(init_wr), .init_addr(init_addr),
    .init_data(init_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .delta_k(delta_k), .out_valid(out_valid),
    .out_ready(out_ready), .out_net(out_net), .busy(busy), .done(done)
  );

  int n_vec = 0, n_bad = 0, n_done = 0;

  // Reference: bias table as integers, pass progress as an accept count.
  int          bias [N];
  bit          in_pass, fin, ov, m_tr;
  int          m_eta, n_acc;
  logic [15:0] m_net;
  logic [15:0] obs_net [N];
  logic [15:0] sums [N];
  logic [15:0] deltas [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int upd_bias(input int b, input int d, input int e);
    longint p;
    p = longint'(d) * longint'(e);
    p = p >>> FRAC;
    return sat16(b - sat16(int'(p)));
  endfunction

  // One clock: check combinational ready, advance the model, check registered outputs.
  task automatic cyc();
    bit rdy, acc, idle;
    int ai;
    #1;
    rdy = in_pass && (!ov || out_ready);
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc  = ap_rst_n && ap_ce && in_valid && rdy;
    ai   = n_acc % N;
    idle = !in_pass && !fin;
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      foreach (bias[i]) bias[i] = 0;
      in_pass = 0; fin = 0; ov = 0; m_tr = 0; m_eta = 0; n_acc = 0; m_net = '0;
    end else if (ap_ce) begin
      if (idle && init_wr) bias[init_addr] = s16(init_data);
      if (acc) begin
        m_net = 16'(sat16(bias[ai] + s16(sum_in)));
        ov    = 1;
        if (m_tr) bias[ai] = upd_bias(bias[ai], s16(delta_k), m_eta);
      end else if (out_ready) begin
        ov = 0;
      end
      fin = acc && (n_acc == N - 1);
      if (acc) n_acc++;
      if (fin) in_pass = 0;
      if (idle && start) begin
        in_pass = 1; n_acc = 0; m_tr = training; m_eta = s16(eta);
      end
    end
    @(negedge ap_clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, ov});
    check("out_net", {16'b0, out_net}, {16'b0, m_net});
    check("busy", {31'b0, busy}, {31'b0, in_pass || fin});
    check("done", {31'b0, done}, {31'b0, fin});
    if (acc) obs_net[ai] = out_net;
    if (done === 1'b1) n_done++;
  endtask

  task automatic init_bias(input int a, input logic [15:0] d);
    init_wr = 1; init_addr = IW'(a); init_data = d;
    cyc();
    init_wr = 0;
  endtask

  task automatic do_pass(input bit tr, input logic [15:0] e, input int vprob, input int rprob,
                         input int stall_at, input int abort_at, input bit noisy, input bit drain);
    int d0;
    bit stalled, aborted;
    logic [15:0] held;
    d0 = n_done; stalled = 0; aborted = 0;
    start = 1; training = tr; eta = e; in_valid = 0;
    out_ready = ($urandom_range(99) < rprob);
    cyc();
    start = 0; training = 1'($urandom); eta = 16'($urandom);
    for (int c = 0; c < 600 && (in_pass || fin || (drain && ov)); c++) begin
      sum_in = sums[n_acc % N]; delta_k = deltas[n_acc % N];
      if (in_pass && n_acc == abort_at) begin
        ap_rst_n = 0; in_valid = 1;
        cyc();
        ap_rst_n = 1; in_valid = 0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ovld", {31'b0, out_valid}, 32'd0);
        aborted = 1;
        break;
      end
      if (in_pass && n_acc == stall_at && !stalled) begin
        stalled = 1; in_valid = 1; out_ready = 0;
        cyc();
        held = out_net;
        repeat (5) begin
          cyc();
          check("bp_net", {16'b0, out_net}, {16'b0, held});
          check("bp_rdy", {31'b0, in_ready}, 32'd0);
        end
        ap_ce = 0; out_ready = 1;
        repeat (3) begin
          cyc();
          check("ce_net", {16'b0, out_net}, {16'b0, held});
          check("ce_vld", {31'b0, out_valid}, 32'd1);
          check("ce_busy", {31'b0, busy}, 32'd1);
        end
        ap_ce = 1;
        continue;
      end
      in_valid  = ($urandom_range(99) < vprob);
      out_ready = ($urandom_range(99) < rprob);
      if (noisy && in_pass) begin
        start = 1'($urandom); init_wr = 1'($urandom);
        init_addr = IW'($urandom); init_data = 16'($urandom);
        ap_ce = ($urandom_range(3) != 0);
      end
      cyc();
      start = 0; init_wr = 0; ap_ce = 1;
    end
    if (in_pass || fin || (drain && ov)) check("pass_timeout", 32'd1, 32'd0);
    if (!aborted) check("done_cnt", n_done - d0, 32'd1);
    in_valid = 0; out_ready = 1;
  endtask

  task automatic readback();
    foreach (sums[i]) sums[i] = '0;
    do_pass(0, 16'h0, 100, 100, -1, -1, 0, 1);
  endtask

  task automatic rand_data();
    foreach (sums[i]) begin
      sums[i]   = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      deltas[i] = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
    end
  endtask

  initial begin
    ap_rst_n = 0; ap_ce = 1; start = 0; training = 0; eta = '0; init_wr = 0;
    init_addr = '0; init_data = '0; in_valid = 0; out_ready = 1; sum_in = '0; delta_k = '0;
    in_pass = 0; fin = 0; ov = 0; m_tr = 0; m_eta = 0; n_acc = 0; m_net = '0;
    foreach (bias[i]) bias[i] = 0;
    rand_data();
    @(posedge ap_clk);
    @(negedge ap_clk);
    cyc();
    ap_rst_n = 1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovld", {31'b0, out_valid}, 32'd0);
    check("rst_net", {16'b0, out_net}, 32'd0);

    // Forward only: bias unchanged.
    init_bias(0, 16'h0100);
    sums[0] = 16'h0200;
    do_pass(0, 16'h0080, 100, 100, -1, -1, 0, 1);
    check("fwd_net", {16'b0, obs_net[0]}, 32'h0300);
    readback();
    check("fwd_bias", {16'b0, obs_net[0]}, 32'h0100);

    // Training step.
    rand_data(); sums[0] = 16'h0200; deltas[0] = 16'h0100;
    do_pass(1, 16'h0080, 100, 100, -1, -1, 0, 1);
    check("upd_net", {16'b0, obs_net[0]}, 32'h0300);
    readback();
    check("upd_bias", {16'b0, obs_net[0]}, 32'h0080);

    // Saturation of the forward sum and of the bias update.
    init_bias(0, 16'h7F00);
    init_bias(1, 16'h8100);
    rand_data(); sums[0] = 16'h0200; deltas[0] = '0; deltas[1] = 16'h7FFF;
    do_pass(1, 16'h7FFF, 100, 100, -1, -1, 0, 1);
    check("sat_net", {16'b0, obs_net[0]}, 32'h7FFF);
    readback();
    check("sat_bias", {16'b0, obs_net[1]}, 32'h8000);

    // Backpressure and clock-enable freeze mid-pass.
    rand_data();
    do_pass(0, 16'h0040, 100, 100, 3, -1, 0, 1);

    // Ignored start/init_wr during RUN, random ce, random handshakes.
    rand_data();
    do_pass(1, 16'h0100, 70, 60, -1, -1, 1, 1);
    readback();

    // Back-to-back passes starting while the last output is still pending.
    for (int p = 0; p < 4; p++) begin
      rand_data();
      for (int i = 0; i < N; i++) if ($urandom_range(1) == 1) init_bias(i, 16'($urandom));
      do_pass(1'($urandom), 16'($urandom_range(0, 511)), 80, 40, -1, -1, 0, 0);
    end
    do_pass(0, 16'h0, 100, 100, -1, -1, 0, 1);

    // Reset mid-pass clears table and abandons the pass.
    rand_data();
    do_pass(1, 16'h0100, 100, 100, -1, 3, 0, 1);
    readback();
    for (int i = 0; i < N; i++) check("rst_bias", {16'b0, obs_net[i]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
